// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the PC, drives a 1-cycle-latency ROM and
// buffers returned words with their addresses in a small FIFO for decode.
module fetch_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump_flag,
  input  logic [ADDR_WIDTH-1:0]   jump_addr,
  input  logic                    stall,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic                    imem_rd_en,
  input  logic [DATA_WIDTH-1:0]   imem_data,
  output logic [DATA_WIDTH-1:0]   inst,
  output logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_valid,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_qdata [DEPTH];
  logic [ADDR_WIDTH-1:0] r_qaddr [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic w_valid;
  logic w_credit_ok;
  logic w_issue;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_valid     = (r_count != '0);
    // An in-flight read already owns a slot, so it counts against capacity.
    w_credit_ok = ({1'b0, r_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(DEPTH);
    // rst gates the strobe so the ROM sees no read while reset is asserted.
    w_issue     = rst && !jump_flag && w_credit_ok;
    w_push      = r_inflight && !jump_flag;
    w_pop       = w_valid && !stall && !jump_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_cap_addr <= '0;
      r_inflight <= 1'b0;
    end else if (jump_flag) begin
      r_pc       <= jump_addr;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= r_pc + ADDR_WIDTH'(1);
      r_cap_addr <= r_pc;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (jump_flag) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qdata[r_wptr] <= imem_data;
      r_qaddr[r_wptr] <= r_cap_addr;
    end
  end

  assign imem_addr  = r_pc;
  assign imem_rd_en = w_issue;
  assign inst_valid = w_valid;
  assign inst       = w_valid ? r_qdata[r_rptr] : '0;
  assign inst_addr  = w_valid ? r_qaddr[r_rptr] : '0;
  assign q_count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM returns 8'hA0 + address one cycle after a read strobe.
module tb_fetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       jump_flag;
  logic [3:0] jump_addr;
  logic       stall;
  logic [3:0] imem_addr;
  logic       imem_rd_en;
  logic [7:0] imem_data;
  logic [7:0] inst;
  logic [3:0] inst_addr;
  logic       inst_valid;
  logic [2:0] q_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .jump_flag  (jump_flag),
    .jump_addr  (jump_addr),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_data  (imem_data),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .q_count    (q_count)
  );

  always_ff @(posedge clk) begin
    if (imem_rd_en) imem_data <= 8'hA0 + {4'h0, imem_addr};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [3:0] a);
    check({tag, ".valid"}, 32'(inst_valid), 32'd1);
    check({tag, ".addr"},  32'(inst_addr),  32'(a));
    check({tag, ".inst"},  32'(inst),       32'(8'hA0 + {4'h0, a}));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".valid"}, 32'(inst_valid), 32'd0);
    check({tag, ".inst"},  32'(inst),       32'd0);
    check({tag, ".addr"},  32'(inst_addr),  32'd0);
  endtask

  // Called right after reset is released mid-cycle; that cycle is cycle 0.
  task automatic stream_from_reset(input string tag, input int n);
    #1;
    check({tag, ".c0_rd_en"}, 32'(imem_rd_en), 32'd1);
    check({tag, ".c0_addr"},  32'(imem_addr),  32'd0);
    check({tag, ".c0_cnt"},   32'(q_count),    32'd0);
    expect_empty({tag, ".c0"});
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      check({tag, ".rd_en"}, 32'(imem_rd_en), 32'd1);
      if (k == 1) begin
        expect_empty({tag, ".c1"});
      end else begin
        expect_head({tag, ".seq"}, 4'(k - 2));
        check({tag, ".cnt"}, 32'(q_count), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; jump_flag = 1'b0; jump_addr = 4'h0;
    repeat (2) @(negedge clk);
    check("rst.rd_en", 32'(imem_rd_en), 32'd0);
    check("rst.imem_addr", 32'(imem_addr), 32'd0);
    check("rst.cnt", 32'(q_count), 32'd0);
    expect_empty("rst");

    // Tests 1 and 2: reset release, steady stream through the PC wrap
    rst = 1'b1;
    stream_from_reset("t1", 22);

    // Test 3: stall for cycles 22..31, head stays at address 4
    for (int c = 22; c <= 31; c++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      expect_head("t3.hold", 4'h4);
      check("t3.cnt", 32'(q_count), (c - 21 > 4) ? 32'd4 : 32'(c - 21));
      check("t3.rd_en", 32'(imem_rd_en), (c < 24) ? 32'd1 : 32'd0);
    end
    check("t3.pc_hold", 32'(imem_addr), 32'd8);
    @(negedge clk);
    stall = 1'b0;
    #1;
    expect_head("t3.drain0", 4'h4);
    check("t3.rd_en_full", 32'(imem_rd_en), 32'd0);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      expect_head("t3.drain", 4'(4 + j));
      if (j == 1) check("t3.rd_en_resume", 32'(imem_rd_en), 32'd1);
    end

    // Test 4: jump to 9 while three entries are queued
    @(negedge clk);
    stall = 1'b1;
    #1;
    check("t4.pre_cnt", 32'(q_count), 32'd2);
    @(negedge clk);
    stall = 1'b0; jump_flag = 1'b1; jump_addr = 4'h9;
    #1;
    check("t4.cnt3", 32'(q_count), 32'd3);
    expect_head("t4.j", 4'hC);
    check("t4.j_rd_en", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    jump_flag = 1'b0;
    #1;
    check("t4.flush_cnt", 32'(q_count), 32'd0);
    expect_empty("t4.j1");
    check("t4.j1_addr", 32'(imem_addr), 32'd9);
    check("t4.j1_rd_en", 32'(imem_rd_en), 32'd1);
    @(negedge clk);
    expect_empty("t4.j2");
    @(negedge clk); expect_head("t4.j3", 4'h9);
    @(negedge clk); expect_head("t4.j4", 4'hA);
    @(negedge clk); expect_head("t4.j5", 4'hB);

    // Test 5: jump together with stall, response for D in flight
    @(negedge clk);
    jump_flag = 1'b1; jump_addr = 4'h2; stall = 1'b1;
    #1;
    check("t5.rd_en", 32'(imem_rd_en), 32'd0);
    expect_head("t5.j", 4'hC);
    @(negedge clk);
    jump_flag = 1'b0; stall = 1'b0;
    #1;
    check("t5.cnt", 32'(q_count), 32'd0);
    expect_empty("t5.j1");
    check("t5.pc", 32'(imem_addr), 32'd2);
    @(negedge clk); expect_empty("t5.j2");
    @(negedge clk); expect_head("t5.j3", 4'h2);
    @(negedge clk); expect_head("t5.j4", 4'h3);

    // Back-to-back jumps: the last target wins
    @(negedge clk);
    jump_flag = 1'b1; jump_addr = 4'h5;
    #1;
    check("bb.rd_en0", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    jump_addr = 4'h7;
    #1;
    check("bb.pc5", 32'(imem_addr), 32'd5);
    check("bb.rd_en1", 32'(imem_rd_en), 32'd0);
    check("bb.cnt", 32'(q_count), 32'd0);
    @(negedge clk);
    jump_flag = 1'b0;
    #1;
    check("bb.pc7", 32'(imem_addr), 32'd7);
    expect_empty("bb.j1");
    @(negedge clk); expect_empty("bb.j2");
    @(negedge clk); expect_head("bb.j3", 4'h7);
    @(negedge clk); expect_head("bb.j4", 4'h8);

    // Test 6: asynchronous reset pulse between edges
    #2;
    rst = 1'b0;
    #1;
    check("t6.rd_en", 32'(imem_rd_en), 32'd0);
    check("t6.pc", 32'(imem_addr), 32'd0);
    check("t6.cnt", 32'(q_count), 32'd0);
    expect_empty("t6.async");
    @(negedge clk);
    expect_empty("t6.held");
    rst = 1'b1;
    stream_from_reset("t6", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
